// File: rtl/bridge_pkg.sv
// Shared encodings and constants for the SRAM-to-AXI3 bridge.
package bridge_pkg;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_AR   = 2'd1,
        R_R    = 2'd2
    } rd_state_e;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_AW   = 2'd1,
        W_B    = 2'd2
    } wr_state_e;

    localparam logic [3:0] ID_INST    = 4'd0;
    localparam logic [3:0] ID_DATA    = 4'd1;
    localparam logic [1:0] BURST_INCR = 2'b01;

    // SRAM size (bytes = 2**size, at most 4) widened to the AXI3 size field.
    function automatic logic [2:0] axi_size(input logic [1:0] size);
        return {1'b0, size};
    endfunction

endpackage

// File: rtl/sram_axi_wr.sv
// Write path of the bridge: one outstanding single-beat AXI3 write.
// AW and W are issued together; each valid drops on its own handshake.
module sram_axi_wr
    import bridge_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,
    input  logic        i_accept,
    input  logic [31:0] i_addr,
    input  logic [1:0]  i_size,
    input  logic [3:0]  i_wstrb,
    input  logic [31:0] i_wdata,
    output logic        o_idle,
    output logic        o_data_ok,
    output logic [31:0] o_awaddr,
    output logic [2:0]  o_awsize,
    output logic        o_awvalid,
    input  logic        i_awready,
    output logic [31:0] o_wdata,
    output logic [3:0]  o_wstrb,
    output logic        o_wvalid,
    input  logic        i_wready,
    input  logic        i_bvalid,
    output logic        o_bready
);

    wr_state_e   r_state;
    logic        r_aw_done;
    logic        r_w_done;
    logic        r_awvalid;
    logic        r_wvalid;
    logic        r_bready;
    logic [31:0] r_addr;
    logic [1:0]  r_size;
    logic [3:0]  r_wstrb;
    logic [31:0] r_wdata;

    logic        w_aw_fin;
    logic        w_w_fin;

    // A channel counts as finished if it handshook earlier or is handshaking now.
    assign w_aw_fin = r_aw_done | (r_awvalid & i_awready);
    assign w_w_fin  = r_w_done | (r_wvalid & i_wready);

    // Write FSM: latch request, drive AW/W until both handshake, then wait for B.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state   <= W_IDLE;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
            r_awvalid <= 1'b0;
            r_wvalid  <= 1'b0;
            r_bready  <= 1'b0;
            r_addr    <= 32'd0;
            r_size    <= 2'd0;
            r_wstrb   <= 4'd0;
            r_wdata   <= 32'd0;
        end else begin
            unique case (r_state)
                W_IDLE: begin
                    if (i_accept) begin
                        r_addr    <= i_addr;
                        r_size    <= i_size;
                        r_wstrb   <= i_wstrb;
                        r_wdata   <= i_wdata;
                        r_awvalid <= 1'b1;
                        r_wvalid  <= 1'b1;
                        r_aw_done <= 1'b0;
                        r_w_done  <= 1'b0;
                        r_state   <= W_AW;
                    end
                end
                W_AW: begin
                    if (r_awvalid && i_awready) begin
                        r_awvalid <= 1'b0;
                        r_aw_done <= 1'b1;
                    end
                    if (r_wvalid && i_wready) begin
                        r_wvalid <= 1'b0;
                        r_w_done <= 1'b1;
                    end
                    if (w_aw_fin && w_w_fin) begin
                        r_bready <= 1'b1;
                        r_state  <= W_B;
                    end
                end
                W_B: begin
                    if (i_bvalid) begin
                        r_bready <= 1'b0;
                        r_state  <= W_IDLE;
                    end
                end
                default: r_state <= W_IDLE;
            endcase
        end
    end

    assign o_idle    = (r_state == W_IDLE);
    assign o_data_ok = r_bready & i_bvalid;
    assign o_awaddr  = r_addr;
    assign o_awsize  = axi_size(r_size);
    assign o_awvalid = r_awvalid;
    assign o_wdata   = r_wdata;
    assign o_wstrb   = r_wstrb;
    assign o_wvalid  = r_wvalid;
    assign o_bready  = r_bready;

endmodule

// File: rtl/sram_axi_bridge.sv
// Bridges the core's instruction and data SRAM-like ports onto one AXI3 master.
// One read and one write may be outstanding; data reads beat instruction reads.
module sram_axi_bridge
    import bridge_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,

    input  logic        inst_sram_req,
    input  logic        inst_sram_wr,
    input  logic [1:0]  inst_sram_size,
    input  logic [3:0]  inst_sram_wstrb,
    input  logic [31:0] inst_sram_addr,
    input  logic [31:0] inst_sram_wdata,
    output logic        inst_sram_addr_ok,
    output logic        inst_sram_data_ok,
    output logic [31:0] inst_sram_rdata,

    input  logic        data_sram_req,
    input  logic        data_sram_wr,
    input  logic [1:0]  data_sram_size,
    input  logic [3:0]  data_sram_wstrb,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic        data_sram_addr_ok,
    output logic        data_sram_data_ok,
    output logic [31:0] data_sram_rdata,

    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [3:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    output logic [1:0]  arlock,
    output logic [3:0]  arcache,
    output logic [2:0]  arprot,
    output logic        arvalid,
    input  logic        arready,

    input  logic [3:0]  rid,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rlast,
    input  logic        rvalid,
    output logic        rready,

    output logic [3:0]  awid,
    output logic [31:0] awaddr,
    output logic [3:0]  awlen,
    output logic [2:0]  awsize,
    output logic [1:0]  awburst,
    output logic [1:0]  awlock,
    output logic [3:0]  awcache,
    output logic [2:0]  awprot,
    output logic        awvalid,
    input  logic        awready,

    output logic [3:0]  wid,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic        wlast,
    output logic        wvalid,
    input  logic        wready,

    input  logic [3:0]  bid,
    input  logic [1:0]  bresp,
    input  logic        bvalid,
    output logic        bready
);

    rd_state_e   r_rstate;
    logic [31:0] r_raddr;
    logic [1:0]  r_rsize;
    logic [3:0]  r_rid;
    logic        r_arvalid;
    logic        r_rready;

    logic        w_wr_idle;
    logic        w_wr_data_ok;
    logic        w_rd_idle;
    logic        w_data_rd;
    logic        w_rd_data;
    logic        w_rd_inst;
    logic        w_rd_accept;
    logic        w_wr_accept;
    logic        w_r_fire;
    logic        w_unused;

    assign w_rd_idle = (r_rstate == R_IDLE);
    assign w_data_rd = data_sram_req & ~data_sram_wr;

    // Reads wait for an idle write path to avoid read-after-write hazards.
    assign w_rd_data   = w_rd_idle & w_wr_idle & w_data_rd;
    assign w_rd_inst   = w_rd_idle & w_wr_idle & inst_sram_req & ~w_data_rd;
    assign w_rd_accept = w_rd_data | w_rd_inst;

    // A write may overlap only an instruction read. An instruction read being
    // accepted this cycle goes first so the two addr_ok strobes never coincide.
    assign w_wr_accept = data_sram_req & data_sram_wr & w_wr_idle & ~w_rd_inst &
                         (w_rd_idle | (r_rid == ID_INST));

    assign w_r_fire = r_rready & rvalid;

    // Read FSM: latch the winning request, issue AR, then wait for R.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_rstate  <= R_IDLE;
            r_raddr   <= 32'd0;
            r_rsize   <= 2'd0;
            r_rid     <= 4'd0;
            r_arvalid <= 1'b0;
            r_rready  <= 1'b0;
        end else begin
            unique case (r_rstate)
                R_IDLE: begin
                    if (w_rd_accept) begin
                        r_raddr   <= w_rd_data ? data_sram_addr : inst_sram_addr;
                        r_rsize   <= w_rd_data ? data_sram_size : inst_sram_size;
                        r_rid     <= w_rd_data ? ID_DATA : ID_INST;
                        r_arvalid <= 1'b1;
                        r_rstate  <= R_AR;
                    end
                end
                R_AR: begin
                    if (arready) begin
                        r_arvalid <= 1'b0;
                        r_rready  <= 1'b1;
                        r_rstate  <= R_R;
                    end
                end
                R_R: begin
                    if (rvalid) begin
                        r_rready <= 1'b0;
                        r_rstate <= R_IDLE;
                    end
                end
                default: r_rstate <= R_IDLE;
            endcase
        end
    end

    sram_axi_wr u_wr (
        .clk       (clk),
        .resetn    (resetn),
        .i_accept  (w_wr_accept),
        .i_addr    (data_sram_addr),
        .i_size    (data_sram_size),
        .i_wstrb   (data_sram_wstrb),
        .i_wdata   (data_sram_wdata),
        .o_idle    (w_wr_idle),
        .o_data_ok (w_wr_data_ok),
        .o_awaddr  (awaddr),
        .o_awsize  (awsize),
        .o_awvalid (awvalid),
        .i_awready (awready),
        .o_wdata   (wdata),
        .o_wstrb   (wstrb),
        .o_wvalid  (wvalid),
        .i_wready  (wready),
        .i_bvalid  (bvalid),
        .o_bready  (bready)
    );

    assign inst_sram_addr_ok = w_rd_inst;
    assign data_sram_addr_ok = w_rd_data | w_wr_accept;

    // rid[0] routes the returning beat; a write response can only be for data.
    assign inst_sram_data_ok = w_r_fire & ~rid[0];
    assign data_sram_data_ok = (w_r_fire & rid[0]) | w_wr_data_ok;
    assign inst_sram_rdata   = rdata;
    assign data_sram_rdata   = rdata;

    assign arid    = r_rid;
    assign araddr  = r_raddr;
    assign arlen   = 4'd0;
    assign arsize  = axi_size(r_rsize);
    assign arburst = BURST_INCR;
    assign arlock  = 2'd0;
    assign arcache = 4'd0;
    assign arprot  = 3'd0;
    assign arvalid = r_arvalid;
    assign rready  = r_rready;

    assign awid    = ID_DATA;
    assign awlen   = 4'd0;
    assign awburst = BURST_INCR;
    assign awlock  = 2'd0;
    assign awcache = 4'd0;
    assign awprot  = 3'd0;

    assign wid   = ID_DATA;
    assign wlast = 1'b1;

    // Inputs the bridge deliberately ignores.
    assign w_unused = ^{inst_sram_wr, inst_sram_wstrb, inst_sram_wdata, rresp, rlast,
                        rid[3:1], bid, bresp};

endmodule

// File: tb/tb_sram_axi_bridge.sv
// Self-checking bench for sram_axi_bridge: idle arbitration table, scripted
// corner cases and randomized traffic against a transaction-level model.
module tb_sram_axi_bridge;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;

    logic        inst_sram_req, inst_sram_wr;
    logic [1:0]  inst_sram_size;
    logic [3:0]  inst_sram_wstrb;
    logic [31:0] inst_sram_addr, inst_sram_wdata;
    logic        inst_sram_addr_ok, inst_sram_data_ok;
    logic [31:0] inst_sram_rdata;
    logic        data_sram_req, data_sram_wr;
    logic [1:0]  data_sram_size;
    logic [3:0]  data_sram_wstrb;
    logic [31:0] data_sram_addr, data_sram_wdata;
    logic        data_sram_addr_ok, data_sram_data_ok;
    logic [31:0] data_sram_rdata;

    logic [3:0]  arid, arlen, arcache;
    logic [31:0] araddr;
    logic [2:0]  arsize, arprot;
    logic [1:0]  arburst, arlock;
    logic        arvalid, arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast, rvalid, rready;
    logic [3:0]  awid, awlen, awcache;
    logic [31:0] awaddr;
    logic [2:0]  awsize, awprot;
    logic [1:0]  awburst, awlock;
    logic        awvalid, awready;
    logic [3:0]  wid, wstrb;
    logic [31:0] wdata;
    logic        wlast, wvalid, wready;
    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid, bready;

    sram_axi_bridge dut (
        .clk(clk), .resetn(resetn),
        .inst_sram_req(inst_sram_req), .inst_sram_wr(inst_sram_wr),
        .inst_sram_size(inst_sram_size), .inst_sram_wstrb(inst_sram_wstrb),
        .inst_sram_addr(inst_sram_addr), .inst_sram_wdata(inst_sram_wdata),
        .inst_sram_addr_ok(inst_sram_addr_ok), .inst_sram_data_ok(inst_sram_data_ok),
        .inst_sram_rdata(inst_sram_rdata),
        .data_sram_req(data_sram_req), .data_sram_wr(data_sram_wr),
        .data_sram_size(data_sram_size), .data_sram_wstrb(data_sram_wstrb),
        .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata),
        .data_sram_addr_ok(data_sram_addr_ok), .data_sram_data_ok(data_sram_data_ok),
        .data_sram_rdata(data_sram_rdata),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid),
        .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid),
        .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid),
        .awready(awready),
        .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid),
        .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: what is outstanding and which AXI phase it is in.
    logic        m_rd_busy, m_rd_phase;   // phase 0: address pending, 1: data pending
    logic [3:0]  m_rd_id;
    logic [31:0] m_rd_addr;
    logic [1:0]  m_rd_size;
    logic        m_wr_busy, m_aw_done, m_w_done;
    logic [31:0] m_wr_addr, m_wr_data;
    logic [1:0]  m_wr_size;
    logic [3:0]  m_wr_strb;

    task automatic model_clear();
        m_rd_busy = 1'b0; m_rd_phase = 1'b0; m_rd_id = 4'd0; m_rd_addr = 32'd0;
        m_rd_size = 2'd0; m_wr_busy = 1'b0; m_aw_done = 1'b0; m_w_done = 1'b0;
        m_wr_addr = 32'd0; m_wr_data = 32'd0; m_wr_size = 2'd0; m_wr_strb = 4'd0;
    endtask

    task automatic drive_idle();
        inst_sram_req = 1'b0; inst_sram_wr = 1'b0; inst_sram_size = 2'd0;
        inst_sram_wstrb = 4'd0; inst_sram_addr = 32'd0; inst_sram_wdata = 32'd0;
        data_sram_req = 1'b0; data_sram_wr = 1'b0; data_sram_size = 2'd0;
        data_sram_wstrb = 4'd0; data_sram_addr = 32'd0; data_sram_wdata = 32'd0;
        arready = 1'b0; rid = 4'd0; rdata = 32'd0; rresp = 2'd0; rlast = 1'b1;
        rvalid = 1'b0; awready = 1'b0; wready = 1'b0; bid = 4'd0; bresp = 2'd0;
        bvalid = 1'b0;
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        drive_idle();
        model_clear();
        repeat (2) @(negedge clk);
        resetn = 1'b1;
    endtask

    // Called just after inputs change at a negedge: compare every output with
    // the model, advance the model across the coming posedge, return at next negedge.
    task automatic tick();
        logic e_iaok, e_draok, e_dwaok, rd_ret, wr_ret, e_arv, e_awv, e_wv, e_br;
        #1;
        e_draok = data_sram_req && !data_sram_wr && !m_rd_busy && !m_wr_busy;
        e_iaok  = inst_sram_req && !(data_sram_req && !data_sram_wr) &&
                  !m_rd_busy && !m_wr_busy;
        e_dwaok = data_sram_req && data_sram_wr && !m_wr_busy && !e_iaok &&
                  (!m_rd_busy || m_rd_id == 4'd0);
        rd_ret  = m_rd_busy && m_rd_phase && rvalid;
        e_br    = m_wr_busy && m_aw_done && m_w_done;
        wr_ret  = e_br && bvalid;
        e_arv   = m_rd_busy && !m_rd_phase;
        e_awv   = m_wr_busy && !m_aw_done;
        e_wv    = m_wr_busy && !m_w_done;

        chk("inst_addr_ok", 32'(inst_sram_addr_ok), 32'(e_iaok));
        chk("data_addr_ok", 32'(data_sram_addr_ok), 32'(e_draok | e_dwaok));
        chk("inst_data_ok", 32'(inst_sram_data_ok), 32'(rd_ret && !m_rd_id[0]));
        chk("data_data_ok", 32'(data_sram_data_ok), 32'((rd_ret && m_rd_id[0]) || wr_ret));
        if (rd_ret && !m_rd_id[0]) chk("inst_rdata", inst_sram_rdata, rdata);
        if (rd_ret && m_rd_id[0])  chk("data_rdata", data_sram_rdata, rdata);
        chk("arvalid", 32'(arvalid), 32'(e_arv));
        chk("rready", 32'(rready), 32'(m_rd_busy && m_rd_phase));
        if (e_arv) begin
            chk("araddr", araddr, m_rd_addr);
            chk("arsize", 32'(arsize), 32'({1'b0, m_rd_size}));
            chk("arid", 32'(arid), 32'(m_rd_id));
        end
        chk("awvalid", 32'(awvalid), 32'(e_awv));
        chk("wvalid", 32'(wvalid), 32'(e_wv));
        chk("bready", 32'(bready), 32'(e_br));
        if (e_awv) begin
            chk("awaddr", awaddr, m_wr_addr);
            chk("awsize", 32'(awsize), 32'({1'b0, m_wr_size}));
            chk("awid", 32'(awid), 32'd1);
        end
        if (e_wv) begin
            chk("wdata", wdata, m_wr_data);
            chk("wstrb", 32'(wstrb), 32'(m_wr_strb));
            chk("wid_wlast", 32'({wid, wlast}), 32'({4'd1, 1'b1}));
        end

        if (rd_ret) m_rd_busy = 1'b0;
        else if (e_arv && arready) m_rd_phase = 1'b1;
        if (e_draok || e_iaok) begin
            m_rd_busy  = 1'b1;
            m_rd_phase = 1'b0;
            m_rd_id    = e_draok ? 4'd1 : 4'd0;
            m_rd_addr  = e_draok ? data_sram_addr : inst_sram_addr;
            m_rd_size  = e_draok ? data_sram_size : inst_sram_size;
        end
        if (wr_ret) m_wr_busy = 1'b0;
        else if (m_wr_busy) begin
            if (awready) m_aw_done = 1'b1;
            if (wready)  m_w_done  = 1'b1;
        end
        if (e_dwaok) begin
            m_wr_busy = 1'b1; m_aw_done = 1'b0; m_w_done = 1'b0;
            m_wr_addr = data_sram_addr; m_wr_size = data_sram_size;
            m_wr_strb = data_sram_wstrb; m_wr_data = data_sram_wdata;
        end
        @(negedge clk);
    endtask

    typedef struct {
        logic ireq;
        logic dreq;
        logic dwr;
        logic e_iaok;
        logic e_daok;
    } vec_t;

    vec_t vecs[6];

    initial begin
        // Arbitration from idle: {inst_req, data_req, data_wr} -> {inst_ok, data_ok}
        vecs[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[2] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[3] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        vecs[4] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

        drive_idle();
        model_clear();
        #1;
        chk("rst_arvalid", 32'(arvalid), 32'd0);
        chk("rst_rready", 32'(rready), 32'd0);
        chk("rst_aw_w_b", 32'({awvalid, wvalid, bready}), 32'd0);
        do_reset();
        chk("ar_const", 32'({arlen, arburst, arlock, arcache, arprot}),
            32'({4'd0, 2'b01, 2'd0, 4'd0, 3'd0}));
        chk("aw_const", 32'({awlen, awburst, awlock, awcache, awprot}),
            32'({4'd0, 2'b01, 2'd0, 4'd0, 3'd0}));
        tick();

        // Table: requests are withdrawn before the clock edge, so no state moves.
        for (int i = 0; i < 6; i++) begin
            inst_sram_req = vecs[i].ireq;
            data_sram_req = vecs[i].dreq;
            data_sram_wr  = vecs[i].dwr;
            #1;
            chk($sformatf("tbl%0d_inst_ok", i), 32'(inst_sram_addr_ok), 32'(vecs[i].e_iaok));
            chk($sformatf("tbl%0d_data_ok", i), 32'(data_sram_addr_ok), 32'(vecs[i].e_daok));
            drive_idle();
            @(negedge clk);
        end

        // Instruction read alone.
        inst_sram_req = 1'b1; inst_sram_addr = 32'h1C00_0000; inst_sram_size = 2'd2;
        arready = 1'b1;
        #1 chk("s1_addr_ok", 32'(inst_sram_addr_ok), 32'd1);
        tick();
        inst_sram_req = 1'b0;
        #1 chk("s1_ar", 32'({arvalid, arid, arsize}), 32'({1'b1, 4'd0, 3'd2}));
        tick();
        arready = 1'b0;
        tick();
        rvalid = 1'b1; rid = 4'd0; rdata = 32'h0280_0C0C;
        #1 chk("s1_data_ok", 32'({inst_sram_data_ok, data_sram_data_ok}), 32'b10);
        chk("s1_rdata", inst_sram_rdata, 32'h0280_0C0C);
        tick();
        rvalid = 1'b0;
        tick();

        // Simultaneous instruction and data read.
        inst_sram_req = 1'b1; inst_sram_addr = 32'h1C00_0004; inst_sram_size = 2'd2;
        data_sram_req = 1'b1; data_sram_wr = 1'b0; data_sram_addr = 32'h100;
        data_sram_size = 2'd1;
        #1 chk("s2_arb", 32'({inst_sram_addr_ok, data_sram_addr_ok}), 32'b01);
        tick();
        data_sram_req = 1'b0; arready = 1'b1;
        #1 chk("s2_ar", 32'({arid, arsize}), 32'({4'd1, 3'd1}));
        tick();
        arready = 1'b0; rvalid = 1'b1; rid = 4'd1; rdata = 32'h1234_5678;
        #1 chk("s2_inst_wait", 32'(inst_sram_addr_ok), 32'd0);
        tick();
        rvalid = 1'b0;
        #1 chk("s2_inst_accept", 32'(inst_sram_addr_ok), 32'd1);
        tick();
        inst_sram_req = 1'b0; arready = 1'b1;
        tick();
        arready = 1'b0; rvalid = 1'b1; rid = 4'd0; rdata = 32'hCAFE_0001;
        tick();
        rvalid = 1'b0;
        tick();

        // Split write handshake, then a data read held off until the write retires.
        data_sram_req = 1'b1; data_sram_wr = 1'b1; data_sram_addr = 32'h200;
        data_sram_size = 2'd2; data_sram_wdata = 32'hDEAD_BEEF; data_sram_wstrb = 4'b0011;
        #1 chk("s3_accept", 32'(data_sram_addr_ok), 32'd1);
        tick();
        data_sram_req = 1'b0; wready = 1'b1;
        tick();
        wready = 1'b0;
        #1 chk("s3_split", 32'({awvalid, wvalid}), 32'b10);
        tick();
        awready = 1'b1;
        tick();
        awready = 1'b0;
        data_sram_req = 1'b1; data_sram_wr = 1'b0; data_sram_addr = 32'h300;
        #1 chk("s4_blocked_wb", 32'({bready, data_sram_addr_ok}), 32'b10);
        tick();
        bvalid = 1'b1;
        #1 chk("s3_b_ok", 32'({data_sram_data_ok, data_sram_addr_ok}), 32'b10);
        tick();
        bvalid = 1'b0;
        #1 chk("s4_released", 32'(data_sram_addr_ok), 32'd1);
        tick();
        data_sram_req = 1'b0; arready = 1'b1;
        tick();
        arready = 1'b0; rvalid = 1'b1; rid = 4'd1; rdata = 32'h0000_0300;
        tick();
        rvalid = 1'b0;
        tick();

        // Reset while a read is waiting for its data beat.
        inst_sram_req = 1'b1; inst_sram_addr = 32'h1C00_0010; arready = 1'b1;
        tick();
        inst_sram_req = 1'b0;
        tick();
        arready = 1'b0;
        #1 chk("s5_in_rr", 32'(rready), 32'd1);
        #1 resetn = 1'b0;
        #1 chk("s5_async", 32'({rready, arvalid}), 32'b00);
        model_clear();
        @(negedge clk);
        resetn = 1'b1;
        inst_sram_req = 1'b1; inst_sram_addr = 32'h1C00_0020;
        #1 chk("s5_idle_after", 32'(inst_sram_addr_ok), 32'd1);
        tick();
        inst_sram_req = 1'b0; arready = 1'b1;
        tick();
        arready = 1'b0; rvalid = 1'b1; rid = 4'd0; rdata = 32'h5555_AAAA;
        tick();
        drive_idle();
        tick();

        // Randomized traffic; the slave only presents R/B when a response is due.
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            inst_sram_req   = 1'($urandom_range(0, 1));
            inst_sram_wr    = 1'($urandom_range(0, 1));
            inst_sram_size  = 2'($urandom_range(0, 2));
            inst_sram_wstrb = 4'($urandom);
            inst_sram_addr  = $urandom;
            inst_sram_wdata = $urandom;
            data_sram_req   = 1'($urandom_range(0, 1));
            data_sram_wr    = 1'($urandom_range(0, 1));
            data_sram_size  = 2'($urandom_range(0, 2));
            data_sram_wstrb = 4'($urandom);
            data_sram_addr  = $urandom;
            data_sram_wdata = $urandom;
            arready = 1'($urandom_range(0, 1));
            awready = 1'($urandom_range(0, 1));
            wready  = 1'($urandom_range(0, 1));
            rvalid  = m_rd_busy && m_rd_phase && ($urandom_range(0, 2) != 0);
            rid     = m_rd_id;
            rdata   = $urandom;
            rresp   = 2'($urandom);
            bvalid  = m_wr_busy && m_aw_done && m_w_done && ($urandom_range(0, 1) != 0);
            bid     = 4'($urandom);
            tick();
        end

        // Drain remaining transactions with a bounded budget.
        inst_sram_req = 1'b0; data_sram_req = 1'b0;
        for (int n = 0; n < 100 && (m_rd_busy || m_wr_busy); n++) begin
            arready = 1'b1; awready = 1'b1; wready = 1'b1;
            rvalid  = m_rd_busy && m_rd_phase;
            rid     = m_rd_id;
            bvalid  = m_wr_busy && m_aw_done && m_w_done;
            tick();
        end
        chk("drain_idle", 32'({m_rd_busy, m_wr_busy}), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
